// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Imported by the storage array and the FIFO top.
package fifo_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int DEFAULT_DEPTH = 16;

  // Occupancy needs one extra bit to represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// 1-write/1-read storage array for the synchronous FIFO.
// Synchronous write, combinational read, contents never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered status flags,
// sticky error flags and selectable registered / FWFT read.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         cnt_next;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (rptr),
    .rdata (head)
  );

  always_comb begin
    cnt_next = count;
    if (wr_acc && !rd_acc) begin
      cnt_next = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_next = count - CW'(1);
    end
  end

  // Flags are computed from the next count so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + AW'(1);
      end
      count        <= cnt_next;
      full         <= (cnt_next == CW'(DEPTH));
      empty        <= (cnt_next == '0);
      almost_full  <= (cnt_next >= CW'(AF_THRESH));
      almost_empty <= (cnt_next <= CW'(AE_THRESH));
      overflow     <= (wr_en & full) | (overflow & ~clr_err);
      underflow    <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  if (FWFT) begin : g_fwft
    assign rd_data  = empty ? '0 : head;
    assign rd_valid = ~empty;
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) begin
          rd_data <= head;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: registered-read and FWFT instances
// share one stimulus stream, checked against a queue model.
module tb_param_sync_fifo;

  localparam int DW = 16;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data, fw_rd_data;
  logic          rd_valid, fw_rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic          fw_full, fw_empty, fw_af, fw_ae;
  logic [4:0]    count, fw_count;
  logic          overflow, underflow, fw_ov, fw_un;

  logic [10:0] dut_stat, fw_stat;

  assign dut_stat = {count, full, empty, almost_full,
                     almost_empty, overflow, underflow};
  assign fw_stat  = {fw_count, fw_full, fw_empty, fw_af,
                     fw_ae, fw_ov, fw_un};

  param_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (D),
    .FWFT       (1'b0)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  param_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (D),
    .FWFT       (1'b1)
  ) u_fw (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (fw_rd_data),
    .rd_valid     (fw_rd_valid),
    .full         (fw_full),
    .empty        (fw_empty),
    .almost_full  (fw_af),
    .almost_empty (fw_ae),
    .count        (fw_count),
    .overflow     (fw_ov),
    .underflow    (fw_un),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          wr;
    logic          rd;
    logic          clr;
    logic [DW-1:0] data;
    logic [10:0]   exp;
  } vec_t;

  vec_t tbl [34];

  int            vectors = 0;
  int            miscompares = 0;
  int            mc = 0;
  logic          m_ov = 1'b0;
  logic          m_un = 1'b0;
  logic          exp_rv = 1'b0;
  logic [DW-1:0] last_rd = '0;
  bit            armed = 1'b0;
  logic [DW-1:0] sq [$];
  logic [DW-1:0] fq [$];

  function automatic logic [10:0] pack(input int c, input logic f,
                                       input logic e, input logic a,
                                       input logic b, input logic o,
                                       input logic u);
    logic [4:0] c5;
    c5 = c[4:0];
    return {c5, f, e, a, b, o, u};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd,
                      input logic c, input logic [DW-1:0] d);
    bit wacc;
    bit racc;
    rst = r;
    wr_en = w;
    rd_en = rd;
    clr_err = c;
    wr_data = d;
    @(posedge clk);
    #1;
    if (r) begin
      mc = 0;
      m_ov = 1'b0;
      m_un = 1'b0;
      sq.delete();
      fq.delete();
      exp_rv = 1'b0;
      last_rd = '0;
      armed = 1'b1;
    end else begin
      wacc = w && (mc < D);
      racc = rd && (mc > 0);
      m_ov = (w && mc == D) || (m_ov && !c);
      m_un = (rd && mc == 0) || (m_un && !c);
      if (wacc) begin
        sq.push_back(d);
        fq.push_back(d);
      end
      if (racc) void'(fq.pop_front());
      mc = mc + int'(wacc) - int'(racc);
      exp_rv = racc;
    end
    check("status", 32'(dut_stat),
          32'(pack(mc, mc == D, mc == 0, mc >= D - 2, mc <= 2, m_ov, m_un)));
    check("fw_status", 32'(fw_stat),
          32'(pack(mc, mc == D, mc == 0, mc >= D - 2, mc <= 2, m_ov, m_un)));
    check("fw_rd_valid", 32'(fw_rd_valid), 32'(fq.size() > 0));
    if (fq.size() > 0) check("fw_rd_data", 32'(fw_rd_data), 32'(fq[0]));
    if (r) begin
      check("rst_rd_data", 32'(rd_data), 32'(0));
      check("rst_fw_rd_data", 32'(fw_rd_data), 32'(0));
    end
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
  endtask

  // Scoreboard drain: registered-read output is taken mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("rd_valid", 32'(rd_valid), 32'(exp_rv));
      if (rd_valid) begin
        if (sq.size() == 0) begin
          miscompares++;
          vectors++;
          $display("FAIL sb_empty: got rd_data %0h want no output", rd_data);
        end else begin
          last_rd = sq.pop_front();
          check("rd_data", 32'(rd_data), 32'(last_rd));
        end
      end else begin
        check("rd_hold", 32'(rd_data), 32'(last_rd));
      end
    end
  end

  initial begin
    for (int i = 1; i <= 17; i++) begin
      int c;
      c = (i > 16) ? 16 : i;
      tbl[i-1] = '{1'b0, 1'b1, 1'b0, 1'b0, DW'(i - 1),
                   pack(c, i >= 16, 1'b0, c >= 14, c <= 2, i == 17, 1'b0)};
    end
    for (int i = 1; i <= 17; i++) begin
      int c;
      c = (i > 16) ? 0 : 16 - i;
      tbl[16+i] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,
                    pack(c, 1'b0, c == 0, c >= 14, c <= 2, 1'b1, i == 17)};
    end

    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("reset_state", 32'(dut_stat),
          32'(pack(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));

    for (int i = 0; i < 34; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].data);
      check($sformatf("tbl[%0d]", i), 32'(dut_stat), 32'(tbl[i].exp));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("drain_done", 32'(sq.size()), 32'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("clr_both", 32'({overflow, underflow}), 32'(0));

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, DW'(16'h0100 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, DW'(16'h0200 + i));
      check("wrap_count", 32'(count), 32'(3));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, DW'(16'h0300 + i));
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hDEAD);
    check("sim_full_count", 32'(count), 32'(15));
    check("sim_full_ovf", 32'(overflow), 32'(1));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0400);
    check("sim_mid_count", 32'(count), 32'(5));
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0500);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0501);
    check("pre_rst_count", 32'(count), 32'(7));
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0502);
    check("mid_rst", 32'({count, empty, almost_empty}), 32'({5'd0, 2'b11}));

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, DW'(16'h0600 + i));
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    check("clr_vs_ovf", 32'(overflow), 32'(1));
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("clr_alone", 32'(overflow), 32'(0));

    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    check("clr_vs_unf", 32'(underflow), 32'(1));
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hA5A5);
    check("fwft_data", 32'(fw_rd_data), 32'(16'hA5A5));
    check("fwft_valid", 32'(fw_rd_valid), 32'(1));
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("fwft_pop", 32'({fw_empty, fw_rd_valid}), 32'(2'b10));
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h2222);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("fwft_adv", 32'(fw_rd_data), 32'(16'h2222));
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
